mux_sel_pipe: RTL and testbench



---
 rtl/mux_sel_pipe.sv | 116 +++++++++++
 tb/tb_mux_sel_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: N-way word selector feeding a 2-entry skid-buffered output register.
//
// Ports:
//    clk       rising-edge clock
//    rst_n     asynchronous active-low reset
//    in_data   NUM_IN packed words, input k at [k*WIDTH +: WIDTH]
//    in_sel    index of the word to take, sampled with in_data
//    in_valid  upstream beat valid
//    in_ready  beat can be accepted (driven from the skid valid register)
//    flush     synchronous discard of every buffered beat
//    out_data  selected word
//    out_sel   index that produced out_data
//    out_valid out_data/out_sel valid
//    out_ready downstream accepts
//    err       sticky out-of-range select flag
//
// Optional feature macro: MUX_SEL_PIPE_SEL_CHECK_EN enables the sticky err flag;
// without it err is tied low.
module mux_sel_pipe #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err
);
   // state encoding is {skid_v, main_v}
   typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d, word;
   logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
   logic             accept, xfer, load;
   // indices with no matching input fall through to zero
   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_IN; k++)
         if (in_sel == SEL_W'(k)) word = in_data[k*WIDTH +: WIDTH];
   end
   assign in_ready  = ~state_q[1];
   assign out_valid = state_q[0];
   assign out_data  = main_data_q;
   assign out_sel   = main_sel_q;
   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;
   // a beat presented alongside flush is dropped
   assign load      = accept & ~flush;
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_sel_d  = main_sel_q;
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
      case (state_q)
         EMPTY: if (load) begin
            state_d     = ONE;
            main_data_d = word;
            main_sel_d  = in_sel;
         end
         ONE: if (load && !xfer) begin
            state_d     = FULL;
            skid_data_d = word;
            skid_sel_d  = in_sel;
         end else if (load) begin
            main_data_d = word;
            main_sel_d  = in_sel;
         end else if (xfer) begin
            state_d     = EMPTY;
         end
         FULL: if (xfer) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
         end
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_sel_q  <= '0;
         skid_data_q <= '0;
         skid_sel_q  <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_sel_q  <= main_sel_d;
         skid_data_q <= skid_data_d;
         skid_sel_q  <= skid_sel_d;
      end
   end
`ifdef MUX_SEL_PIPE_SEL_CHECK_EN
   logic err_q, err_d, in_range;
   // a fully populated select space has no out-of-range index
   assign in_range = (NUM_IN == (1 << SEL_W)) || (int'(in_sel) < NUM_IN);
   assign err_d    = err_q | (accept & ~in_range);
   assign err      = err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: scoreboard bench driving a 4-input and a 3-input selector in lockstep.
module tb_mux_sel_pipe;
   logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
   logic [127:0] in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
   logic [1:0]   in_sel = 2'd0;
   logic         in_ready4, out_valid4, err4, in_ready3, out_valid3, err3;
   logic [31:0]  out_data4, out_data3;
   logic [1:0]   out_sel4, out_sel3;
   int           total = 0, bad = 0;
   typedef struct {
      logic [31:0] e4;
      logic [31:0] e3;
      logic [1:0]  s;
   } exp_t;
   exp_t q[$];
   logic err3_exp;

   mux_sel_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready4), .flush(flush), .out_data(out_data4), .out_sel(out_sel4),
      .out_valid(out_valid4), .out_ready(out_ready), .err(err4));

   mux_sel_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_sel(out_sel3),
      .out_valid(out_valid3), .out_ready(out_ready), .err(err3));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] s, input logic [31:0] e4, input logic [31:0] e3);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_sel   = s;
      while (!in_ready4 && n < 50) begin
         step();
         n++;
      end
      if (!in_ready4) chk("send_timeout", 32'd0, 32'd1);
      q.push_back('{e4, e3, s});
      step();
      in_valid = 1'b0;
   endtask

   // monitor: every output transfer must match the oldest expected beat
   always @(negedge clk) begin
      if (rst_n && out_valid4 && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_beat", out_data4, 32'hxxxxxxxx);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data4", out_data4, e.e4);
            chk("out_sel4", {30'd0, out_sel4}, {30'd0, e.s});
            chk("out_valid3", {31'd0, out_valid3}, 32'd1);
            chk("out_data3", out_data3, e.e3);
            chk("out_sel3", {30'd0, out_sel3}, {30'd0, e.s});
         end
      end
   end

   initial begin
`ifdef MUX_SEL_PIPE_SEL_CHECK_EN
      err3_exp = 1'b1;
`else
      err3_exp = 1'b0;
`endif
      step();
      step();
      chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
      chk("rst_out_data", out_data4, 32'd0);
      chk("rst_out_sel", {30'd0, out_sel4}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready4}, 32'd1);
      chk("rst_err", {31'd0, err3}, 32'd0);
      rst_n = 1'b1;
      // basic select
      send(2'd2, 32'h33333333, 32'h33333333);
      chk("basic_valid", {31'd0, out_valid4}, 32'd1);
      chk("basic_data", out_data4, 32'h33333333);
      // streaming, one beat per cycle
      send(2'd0, 32'h11111111, 32'h11111111);
      chk("stream_ready0", {31'd0, in_ready4}, 32'd1);
      send(2'd1, 32'h22222222, 32'h22222222);
      chk("stream_ready1", {31'd0, in_ready4}, 32'd1);
      send(2'd2, 32'h33333333, 32'h33333333);
      chk("stream_ready2", {31'd0, in_ready4}, 32'd1);
      send(2'd3, 32'h44444444, 32'h00000000);
      chk("stream_ready3", {31'd0, in_ready4}, 32'd1);
      step();
      step();
      chk("err4_full_range", {31'd0, err4}, 32'd0);
      chk("err3_after_oor", {31'd0, err3}, {31'd0, err3_exp});
      // back-pressure
      out_ready = 1'b0;
      send(2'd0, 32'h11111111, 32'h11111111);
      send(2'd3, 32'h44444444, 32'h00000000);
      chk("bp_in_ready_low", {31'd0, in_ready4}, 32'd0);
      chk("bp_hold_data", out_data4, 32'h11111111);
      step();
      chk("bp_hold_data2", out_data4, 32'h11111111);
      chk("bp_hold_sel3", {30'd0, out_sel3}, 32'd0);
      out_ready = 1'b1;
      step();
      chk("bp_in_ready_back", {31'd0, in_ready4}, 32'd1);
      chk("bp_second_data", out_data4, 32'h44444444);
      step();
      chk("bp_drained", {31'd0, out_valid4}, 32'd0);
      // flush while FULL with a beat presented
      out_ready = 1'b0;
      send(2'd1, 32'h22222222, 32'h22222222);
      send(2'd2, 32'h33333333, 32'h33333333);
      chk("flush_pre_full", {31'd0, in_ready4}, 32'd0);
      in_valid = 1'b1;
      in_sel   = 2'd0;
      flush    = 1'b1;
      q.delete();
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid4}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready4}, 32'd1);
      chk("flush_err_kept", {31'd0, err3}, {31'd0, err3_exp});
      out_ready = 1'b1;
      step();
      step();
      chk("flush_nothing_left", {31'd0, out_valid4}, 32'd0);
      // explicit out-of-range beat
      send(2'd3, 32'h44444444, 32'h00000000);
      chk("oor_sel3", {30'd0, out_sel3}, 32'd3);
      chk("oor_data3", out_data3, 32'd0);
      step();
      // asynchronous reset while FULL
      out_ready = 1'b0;
      send(2'd0, 32'h11111111, 32'h11111111);
      send(2'd1, 32'h22222222, 32'h22222222);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("arst_out_valid", {31'd0, out_valid4}, 32'd0);
      chk("arst_out_data", out_data4, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready4}, 32'd1);
      chk("arst_err3", {31'd0, err3}, 32'd0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(2'd2, 32'h33333333, 32'h33333333);
      chk("post_rst_valid", {31'd0, out_valid4}, 32'd1);
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      chk("drain_queue", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
